// File: rtl/dafa_pkg.sv
// dafa_pkg: shared width, state enum, Hamming(12,8) codec and encoded constants for the DAFA datapath
package dafa_pkg;
  localparam int DAFA_W = 12;
  localparam logic [DAFA_W-1:0] ENC_ZERO = 12'h000;
  localparam logic [DAFA_W-1:0] ENC_1 = 12'h007;
  localparam logic [DAFA_W-1:0] ENC_2 = 12'h019;
  localparam logic [DAFA_W-1:0] ENC_3 = 12'h01E;
  localparam logic [DAFA_W-1:0] ENC_4 = 12'h02A;
  localparam logic [DAFA_W-1:0] ENC_5 = 12'h02D;
  localparam logic [DAFA_W-1:0] ENC_6 = 12'h033;
  localparam logic [DAFA_W-1:0] ENC_7 = 12'h034;
  localparam logic [DAFA_W-1:0] ENC_11 = 12'h055;
  localparam logic [DAFA_W-1:0] ENC_254 = 12'hF70;
  localparam logic [DAFA_W-1:0] ENC_255 = 12'hF77;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  function automatic logic [7:0] dec(input logic [DAFA_W-1:0] c);
    return {c[11:8], c[6:4], c[2]};
  endfunction
  // parity bits sit at code positions 1,2,4,8 (indices 0,1,3,7)
  function automatic logic [DAFA_W-1:0] enc(input logic [7:0] d);
    logic [DAFA_W-1:0] c;
    c = {d[7:4], 1'b0, d[3:1], 1'b0, d[0], 2'b00};
    c[0] = ^(c & 12'h554);
    c[1] = ^(c & 12'h664);
    c[3] = ^(c & 12'h870);
    c[7] = ^(c & 12'hF00);
    return c;
  endfunction
endpackage

// File: rtl/dafa.sv
// DAFA: combinational adder of two Hamming-encoded bytes plus carry-in; overflow on byte carry-out
module DAFA
  import dafa_pkg::*;
(
  input  logic [DAFA_W-1:0] x_in,
  input  logic [DAFA_W-1:0] y_in,
  input  logic              s_in,
  input  logic              ovf_in,
  output logic [DAFA_W-1:0] x_out,
  output logic [DAFA_W-1:0] y_out,
  output logic [DAFA_W-1:0] s_out,
  output logic              ovf_out
);
  logic [8:0] sum;
  assign sum = {1'b0, dec(x_in)} + {1'b0, dec(y_in)} + {8'd0, s_in};
  assign x_out = x_in;
  assign y_out = y_in;
  assign s_out = enc(sum[7:0]);
  assign ovf_out = ovf_in | sum[8];
endmodule

// File: rtl/dafa_acc.sv
// dafa_acc: multi-operand accumulator folding a handshaked operand burst through one DAFA
module dafa_acc
  import dafa_pkg::*;
#(
  parameter int W = DAFA_W,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             op_valid,
  input  logic [W-1:0]     op_data,
  output logic             op_ready,
  output logic             res_valid,
  output logic [W-1:0]     res_data,
  output logic             res_ovf,
  input  logic             res_ready,
  output logic             busy
);
  state_t state, state_nx;
  logic [W-1:0] acc, s_out, dafa_x_unused, dafa_y_unused;
  logic [LEN_W-1:0] cnt;
  logic ovf, ovf_out, accept, launch;
  DAFA u_dafa (
    .x_in(acc),
    .y_in(op_data),
    .s_in(1'b0),
    .ovf_in(1'b0),
    .x_out(dafa_x_unused),
    .y_out(dafa_y_unused),
    .s_out(s_out),
    .ovf_out(ovf_out)
  );
  assign launch = (state == IDLE) & start;
  assign accept = op_valid & op_ready;
  always_comb begin
    op_ready = state == ACC;
    res_valid = state == DONE;
    res_data = res_valid ? acc : '0;
    res_ovf = res_valid & ovf;
    busy = state != IDLE;
    state_nx = launch ? (len == '0 ? DONE : ACC)
             : (accept && cnt == LEN_W'(1)) ? DONE
             : (res_valid && res_ready) ? IDLE
             : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= ENC_ZERO;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) begin
        acc <= ENC_ZERO;
        ovf <= 1'b0;
        cnt <= len;
      end else if (accept) begin
        acc <= s_out;
        ovf <= ovf | ovf_out;
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dafa_acc.sv
// tb_dafa_acc: randomized and directed checks of dafa_acc against a value-level Hamming/sum model
module tb_dafa_acc;
  import dafa_pkg::*;
  logic clk = 1'b0;
  logic rst, start, op_valid, res_ready;
  logic [3:0] len;
  logic [11:0] op_data;
  logic op_ready, res_valid, res_ovf, busy;
  logic [11:0] res_data;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dafa_acc dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf),
    .res_ready(res_ready), .busy(busy)
  );

  function automatic logic [11:0] m_enc(input int v);
    logic [11:0] c = '0;
    int d = 0;
    for (int p = 1; p <= 12; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = v[d];
        d++;
      end
    for (int k = 1; k <= 8; k *= 2) begin
      logic par = 1'b0;
      for (int p = 1; p <= 12; p++)
        if ((p & k) != 0 && p != k) par ^= c[p-1];
      c[k-1] = par;
    end
    return c;
  endfunction

  function automatic int m_dec(input logic [11:0] c);
    int v = 0;
    int d = 0;
    for (int p = 1; p <= 12; p++)
      if ((p & (p - 1)) != 0) begin
        v |= int'(c[p-1]) << d;
        d++;
      end
    return v;
  endfunction

  function automatic void m_sum(input logic [11:0] ops[$], output logic [11:0] s, output logic o);
    int a = 0;
    o = 1'b0;
    foreach (ops[i]) begin
      a += m_dec(ops[i]);
      if (a > 255) begin
        o = 1'b1;
        a -= 256;
      end
    end
    s = m_enc(a);
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the result handshake.
  task automatic run_burst(input int n, input logic [11:0] ops[$], input int bub_pct, input int rdelay,
                           output logic [11:0] rd, output logic ro, output bit late, output bit to);
    int w;
    to = 0;
    late = 0;
    start = 1'b1;
    len = 4'(n);
    @(negedge clk);
    start = 1'b0;
    foreach (ops[i]) begin
      while ($urandom_range(99) < bub_pct) @(negedge clk);
      op_valid = 1'b1;
      op_data = ops[i];
      w = 0;
      while (!op_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!op_ready) to = 1;
      @(negedge clk);
      op_valid = 1'b0;
      op_data = 12'($urandom);
    end
    if (!res_valid) late = 1;
    w = 0;
    while (!res_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!res_valid) to = 1;
    repeat (rdelay) @(negedge clk);
    rd = res_data;
    ro = res_ovf;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    op_valid = 1'b0;
    op_data = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, op_ready, res_valid, res_ovf, res_data} !== 16'h0) begin
      fails++;
      $display("FAIL reset: busy=%b op_ready=%b res_valid=%b res_ovf=%b res_data=%h, want all 0",
               busy, op_ready, res_valid, res_ovf, res_data);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_three_op;
    logic [11:0] q[$], rd, es;
    logic ro, eo;
    bit late, to;
    q = {12'h007, 12'h019, 12'h02A};
    m_sum(q, es, eo);
    run_burst(3, q, 0, 0, rd, ro, late, to);
    tests++;
    if (rd !== es || ro !== eo || late || to) begin
      fails++;
      $display("FAIL three_op: data=%h ovf=%b late=%0d to=%0d, want data=%h ovf=%b on time", rd, ro, late, to, es, eo);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL three_op_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_stall;
    logic [11:0] q[$], es;
    logic eo;
    q = {12'h02D, 12'h033};
    m_sum(q, es, eo);
    start = 1'b1;
    len = 4'd2;
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b1;
    op_data = q[0];
    tests++;
    if (op_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_ready0: op_ready=%b want 1", op_ready);
    end
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
        fails++;
        $display("FAIL stall_gap: op_ready=%b res_valid=%b want 1/0", op_ready, res_valid);
      end
    end
    op_valid = 1'b1;
    op_data = q[1];
    @(negedge clk);
    op_valid = 1'b0;
    tests++;
    if (res_valid !== 1'b1 || res_data !== es || res_ovf !== eo) begin
      fails++;
      $display("FAIL stall_result: valid=%b data=%h ovf=%b want 1/%h/%b", res_valid, res_data, res_ovf, es, eo);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [11:0] q[$], es;
    logic eo;
    q = {12'hF70, 12'h007};
    m_sum(q, es, eo);
    start = 1'b1;
    len = 4'd2;
    @(negedge clk);
    start = 1'b0;
    foreach (q[i]) begin
      op_valid = 1'b1;
      op_data = q[i];
      @(negedge clk);
    end
    op_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (res_valid !== 1'b1 || res_data !== es || res_ovf !== eo) begin
        fails++;
        $display("FAIL backpressure_hold%0d: valid=%b data=%h ovf=%b want 1/%h/%b", c, res_valid, res_data, res_ovf, es, eo);
      end
      start = (c == 1);
      len = 4'd3;
      @(negedge clk);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_start_ignored: busy=%b res_valid=%b want 0/0", busy, res_valid);
    end
  endtask

  task automatic test_zero_len;
    logic [11:0] q[$], rd;
    logic ro;
    bit late, to;
    run_burst(0, q, 0, 0, rd, ro, late, to);
    tests++;
    if (rd !== 12'h000 || ro !== 1'b0 || late || to) begin
      fails++;
      $display("FAIL zero_len: data=%h ovf=%b late=%0d to=%0d want 000/0 on time", rd, ro, late, to);
    end
  endtask

  task automatic test_reset_mid;
    logic [11:0] q[$], rd;
    logic ro;
    bit late, to;
    start = 1'b1;
    len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b1;
    op_data = 12'h007;
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b op_ready=%b res_valid=%b want 0/0/0", busy, op_ready, res_valid);
    end
    q = {12'h01E};
    run_burst(1, q, 0, 0, rd, ro, late, to);
    tests++;
    if (rd !== m_enc(3) || ro !== 1'b0 || late || to) begin
      fails++;
      $display("FAIL reset_mid_next: data=%h ovf=%b late=%0d to=%0d want %h/0", rd, ro, late, to, m_enc(3));
    end
  endtask

  task automatic test_sticky_ovf;
    logic [11:0] q[$], rd, es;
    logic ro, eo;
    bit late, to;
    q = {12'hF70, 12'h02D, 12'h007};
    m_sum(q, es, eo);
    run_burst(3, q, 0, 1, rd, ro, late, to);
    tests++;
    if (rd !== es || ro !== eo || eo !== 1'b1 || late || to) begin
      fails++;
      $display("FAIL sticky_ovf: data=%h ovf=%b want %h/%b (model ovf must be 1)", rd, ro, es, eo);
    end
    q = {12'h007};
    run_burst(1, q, 0, 0, rd, ro, late, to);
    tests++;
    if (rd !== 12'h007 || ro !== 1'b0) begin
      fails++;
      $display("FAIL ovf_cleared: data=%h ovf=%b want 007/0", rd, ro);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] q[$], rd, es;
    logic ro, eo;
    bit late, to;
    for (int b = 0; b < 25; b++) begin
      int n = $urandom_range(15, 0);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(m_enc($urandom_range(255)));
      m_sum(q, es, eo);
      run_burst(n, q, (b % 3) * 20, $urandom_range(3), rd, ro, late, to);
      tests++;
      if (rd !== es || ro !== eo || to || (late && (b % 3) == 0)) begin
        fails++;
        $display("FAIL random_burst%0d n=%0d: data=%h ovf=%b late=%0d to=%0d want %h/%b", b, n, rd, ro, late, to, es, eo);
      end
    end
  endtask

  initial begin
    test_reset;
    test_three_op;
    test_stall;
    test_backpressure;
    test_zero_len;
    test_reset_mid;
    test_sticky_ovf;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
